// File: rtl/vip_sched_pkg.sv
// rtl/vip_sched_pkg.sv - shared types and defaults for the dual-frame scheduler
package vip_sched_pkg;

  typedef enum logic [1:0] {
    WAIT_CTRL = 2'd0,
    CTRL      = 2'd1,
    RUN       = 2'd2,
    DROP      = 2'd3
  } sched_state_t;

  localparam logic [15:0] DEF_WIDTH  = 16'd640;
  localparam logic [15:0] DEF_HEIGHT = 16'd480;

  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
  } dims_t;

  function automatic logic has_zero_dim(dims_t d);
    return (d.width == 16'd0) || (d.height == 16'd0);
  endfunction

endpackage

// File: rtl/vip_beat_counter.sv
// rtl/vip_beat_counter.sv - beat counter against a loaded terminal count
module vip_beat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] total,
  output logic             last,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == total - CNT_W'(1));
  assign done = (cnt >= total);

endmodule

// File: rtl/vip_dual_frame_scheduler.sv
// rtl/vip_dual_frame_scheduler.sv - pairs A/B control packets and sequences encoder send, run and drop
module vip_dual_frame_scheduler #(
  parameter logic [15:0] DEF_WIDTH  = vip_sched_pkg::DEF_WIDTH,
  parameter logic [15:0] DEF_HEIGHT = vip_sched_pkg::DEF_HEIGHT,
  parameter int          CNT_W      = 32,
  parameter int          ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_ctrl_valid,
  input  logic [15:0]      a_width,
  input  logic [15:0]      a_height,
  input  logic             a_vid_valid,
  input  logic             b_ctrl_valid,
  input  logic [15:0]      b_width,
  input  logic [15:0]      b_height,
  input  logic             b_vid_valid,
  input  logic             pair_fire,
  input  logic             enc_busy,
  output logic             run_en,
  output logic             drop_a,
  output logic             drop_b,
  output logic             enc_ctrl_send,
  output logic [15:0]      enc_width,
  output logic [15:0]      enc_height,
  output logic             frame_done,
  output logic [ERR_W-1:0] mismatch_cnt
);
  import vip_sched_pkg::*;

  sched_state_t     state, state_d;
  dims_t            pend_a, pend_b, frm_a, frm_b;
  logic             got_a, got_b, sent_valid;
  logic             clear_flags, latch_frame, mm_inc, do_send;
  logic [CNT_W-1:0] total_a, total_b;
  logic             run_last, run_done, run_inc;
  logic             da_last, da_done, da_inc, da_fin;
  logic             db_last, db_done, db_inc, db_fin;

  assign total_a = CNT_W'(frm_a.width) * CNT_W'(frm_a.height);
  assign total_b = CNT_W'(frm_b.width) * CNT_W'(frm_b.height);

  assign run_en     = (state == RUN);
  assign run_inc    = run_en && pair_fire && !run_done;
  assign frame_done = run_inc && run_last;

  assign drop_a = (state == DROP) && !da_done;
  assign drop_b = (state == DROP) && !db_done;
  assign da_inc = drop_a && a_vid_valid;
  assign db_inc = drop_b && b_vid_valid;
  // A side is finished once its final beat is being consumed or already was.
  assign da_fin = da_done || (da_last && da_inc);
  assign db_fin = db_done || (db_last && db_inc);

  vip_beat_counter #(.CNT_W(CNT_W)) u_run_cnt (
    .clk(clk), .rst(rst), .clr(state != RUN), .inc(run_inc),
    .total(total_a), .last(run_last), .done(run_done)
  );

  vip_beat_counter #(.CNT_W(CNT_W)) u_drop_a_cnt (
    .clk(clk), .rst(rst), .clr(state != DROP), .inc(da_inc),
    .total(total_a), .last(da_last), .done(da_done)
  );

  vip_beat_counter #(.CNT_W(CNT_W)) u_drop_b_cnt (
    .clk(clk), .rst(rst), .clr(state != DROP), .inc(db_inc),
    .total(total_b), .last(db_last), .done(db_done)
  );

  always_comb begin
    state_d     = state;
    clear_flags = 1'b0;
    latch_frame = 1'b0;
    mm_inc      = 1'b0;
    do_send     = 1'b0;
    case (state)
      WAIT_CTRL: begin
        if (got_a && got_b) begin
          clear_flags = 1'b1;
          if (!has_zero_dim(pend_a) && !has_zero_dim(pend_b)) begin
            latch_frame = 1'b1;
            if (pend_a == pend_b) begin
              state_d = CTRL;
            end else begin
              state_d = DROP;
              mm_inc  = 1'b1;
            end
          end
        end
      end
      CTRL: begin
        if (sent_valid && frm_a.width == enc_width && frm_a.height == enc_height) begin
          state_d = RUN;
        end else if (!enc_busy) begin
          do_send = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (frame_done) state_d = WAIT_CTRL;
      end
      DROP: begin
        if (da_fin && db_fin) state_d = WAIT_CTRL;
      end
      default: state_d = WAIT_CTRL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WAIT_CTRL;
      pend_a        <= '0;
      pend_b        <= '0;
      frm_a         <= '0;
      frm_b         <= '0;
      got_a         <= 1'b0;
      got_b         <= 1'b0;
      sent_valid    <= 1'b0;
      enc_ctrl_send <= 1'b0;
      enc_width     <= DEF_WIDTH;
      enc_height    <= DEF_HEIGHT;
      mismatch_cnt  <= '0;
    end else begin
      state         <= state_d;
      enc_ctrl_send <= do_send;
      // A fresh pulse outranks the clear so a packet arriving on the exit cycle is kept.
      if (a_ctrl_valid) begin
        pend_a <= '{width: a_width, height: a_height};
        got_a  <= 1'b1;
      end else if (clear_flags) begin
        got_a <= 1'b0;
      end
      if (b_ctrl_valid) begin
        pend_b <= '{width: b_width, height: b_height};
        got_b  <= 1'b1;
      end else if (clear_flags) begin
        got_b <= 1'b0;
      end
      if (latch_frame) begin
        frm_a <= pend_a;
        frm_b <= pend_b;
      end
      if (do_send) begin
        enc_width  <= frm_a.width;
        enc_height <= frm_a.height;
        sent_valid <= 1'b1;
      end
      if (mm_inc && mismatch_cnt != {ERR_W{1'b1}}) begin
        mismatch_cnt <= mismatch_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vip_dual_frame_scheduler.sv
// tb/tb_vip_dual_frame_scheduler.sv - directed vector bench for vip_dual_frame_scheduler
module tb_vip_dual_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_ctrl_valid, a_vid_valid, b_ctrl_valid, b_vid_valid;
  logic [15:0] a_width, a_height, b_width, b_height;
  logic        pair_fire, enc_busy;
  logic        run_en, drop_a, drop_b, enc_ctrl_send, frame_done;
  logic [15:0] enc_width, enc_height;
  logic [7:0]  mismatch_cnt;

  int checks = 0;
  int errors = 0;

  vip_dual_frame_scheduler dut (
    .clk(clk), .rst(rst),
    .a_ctrl_valid(a_ctrl_valid), .a_width(a_width), .a_height(a_height), .a_vid_valid(a_vid_valid),
    .b_ctrl_valid(b_ctrl_valid), .b_width(b_width), .b_height(b_height), .b_vid_valid(b_vid_valid),
    .pair_fire(pair_fire), .enc_busy(enc_busy),
    .run_en(run_en), .drop_a(drop_a), .drop_b(drop_b),
    .enc_ctrl_send(enc_ctrl_send), .enc_width(enc_width), .enc_height(enc_height),
    .frame_done(frame_done), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  // kind: 0 = frame runs, 1 = frame pair dropped, 2 = nothing starts
  typedef struct {
    int aw, ah, bw, bh;
    int pa, pb, busy, kind, b_in_run;
    int exp_lat, exp_sends, exp_w, exp_h, exp_mm;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat = 0, sends = 0, sw = 0, sh = 0, na = 0, nb = 0, total;
    bit overlap = 0, fin = 0;
    a_width = 16'(v.aw); a_height = 16'(v.ah);
    b_width = 16'(v.bw); b_height = 16'(v.bh);
    a_ctrl_valid = (v.pa != 0); b_ctrl_valid = (v.pb != 0);
    enc_busy = (v.busy > 0);
    @(posedge clk); #1;
    a_ctrl_valid = 0; b_ctrl_valid = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == v.busy) enc_busy = 0;
      @(negedge clk);
      if (run_en && (drop_a || drop_b)) overlap = 1;
      if (enc_ctrl_send) begin sends++; sw = enc_width; sh = enc_height; end
      if (run_en || drop_a || drop_b) begin lat = c; break; end
      @(posedge clk); #1;
    end
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    if (v.kind == 0 && lat != 0) begin
      total = v.aw * v.ah;
      for (int k = 1; k <= total; k++) begin
        pair_fire = 1;
        if (v.b_in_run != 0) b_ctrl_valid = (k == 1);
        #1;
        check($sformatf("v%0d_frame_done_beat%0d", idx, k), frame_done, (k == total));
        if (k > 1 && enc_ctrl_send) sends++;
        if (drop_a || drop_b) overlap = 1;
        @(negedge clk);
      end
      pair_fire = 0; b_ctrl_valid = 0;
      #1;
      check($sformatf("v%0d_run_en_after_done", idx), run_en, 0);
    end
    if (v.kind == 1 && lat != 0) begin
      for (int k = 0; k < 80; k++) begin
        a_vid_valid = 1;
        b_vid_valid = (k % 3 != 2);
        #1;
        if (run_en) overlap = 1;
        if (!drop_a && !drop_b) begin fin = 1; break; end
        if (drop_a && a_vid_valid) na++;
        if (drop_b && b_vid_valid) nb++;
        @(negedge clk);
      end
      a_vid_valid = 0; b_vid_valid = 0;
      check($sformatf("v%0d_drop_finished", idx), fin, 1);
      check($sformatf("v%0d_drop_a_beats", idx), na, v.aw * v.ah);
      check($sformatf("v%0d_drop_b_beats", idx), nb, v.bw * v.bh);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d_sends", idx), sends, v.exp_sends);
    if (v.exp_sends != 0) begin
      check($sformatf("v%0d_enc_width", idx), sw, v.exp_w);
      check($sformatf("v%0d_enc_height", idx), sh, v.exp_h);
    end
    check($sformatf("v%0d_run_drop_overlap", idx), overlap, 0);
    check($sformatf("v%0d_idle_run_en", idx), run_en, 0);
    check($sformatf("v%0d_mismatch_cnt", idx), mismatch_cnt, v.exp_mm);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_run_en"}, run_en, 0);
    check({tag, "_drop_a"}, drop_a, 0);
    check({tag, "_drop_b"}, drop_b, 0);
    check({tag, "_enc_ctrl_send"}, enc_ctrl_send, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_enc_width"}, enc_width, 640);
    check({tag, "_enc_height"}, enc_height, 480);
    check({tag, "_mismatch_cnt"}, mismatch_cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1;
    a_ctrl_valid = 0; b_ctrl_valid = 0; a_vid_valid = 0; b_vid_valid = 0;
    a_width = 0; a_height = 0; b_width = 0; b_height = 0;
    pair_fire = 0; enc_busy = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 0;
    @(negedge clk);

    //            aw ah bw bh pa pb busy kind bir lat sends w  h  mm
    vecs.push_back('{4, 2, 4, 2, 1, 1, 0, 0, 0, 3, 1, 4, 2, 0});
    vecs.push_back('{4, 2, 4, 2, 1, 1, 0, 0, 0, 3, 0, 0, 0, 0});
    vecs.push_back('{4, 2, 3, 3, 1, 1, 0, 1, 0, 2, 0, 0, 0, 1});
    vecs.push_back('{2, 2, 2, 2, 1, 1, 5, 0, 0, 6, 1, 2, 2, 1});
    vecs.push_back('{3, 1, 3, 1, 1, 1, 0, 0, 1, 3, 1, 3, 1, 1});
    vecs.push_back('{3, 1, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 1});
    vecs.push_back('{4, 0, 4, 2, 1, 1, 0, 2, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{5, 1, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{5, 1, 5, 1, 0, 1, 0, 0, 0, 3, 1, 5, 1, 1});

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset asserted in the middle of a running frame.
    a_width = 2; a_height = 2; b_width = 2; b_height = 2;
    a_ctrl_valid = 1; b_ctrl_valid = 1;
    @(posedge clk); #1;
    a_ctrl_valid = 0; b_ctrl_valid = 0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (run_en) begin seen = 1; break; end
    end
    check("midrun_reached_run", seen, 1);
    pair_fire = 1;
    @(negedge clk);
    pair_fire = 0;
    #2 rst = 1;
    #1;
    check_reset_outputs("midrun_reset");
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    run_vec('{1, 1, 1, 1, 1, 1, 0, 0, 0, 3, 1, 1, 1, 0}, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
